key_debounce: RTL and testbench



---
 rtl/key_debounce_if.sv | 24 ++
 rtl/key_debounce.sv | 144 ++++++++++++++
 tb/tb_key_debounce.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// Key conditioner bundle: raw active-low keys in, clean levels and event pulses out.
// key_state carries the per-channel FSM state (2 bits per key) for observation.
interface key_debounce_if #(
    parameter int N_KEYS = 4
);
    // Event semantics: key_press/key_release/key_long are single-cycle strobes with
    // no handshake; the consumer must sample every cycle and nothing is held or replayed.
    logic [N_KEYS-1:0]   key_n;
    logic [N_KEYS-1:0]   key_level;
    logic [N_KEYS-1:0]   key_press;
    logic [N_KEYS-1:0]   key_release;
    logic [N_KEYS-1:0]   key_long;
    logic [2*N_KEYS-1:0] key_state;

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_long, key_state
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_long, key_state
    );
endinterface

// File: rtl/key_debounce.sv
// Per-key 2-FF synchroniser, stable-count debouncer and press/long/release FSM.
// Every channel owns its own counters; all outputs come straight from flops.
module key_debounce #(
    parameter int N_KEYS    = 4,
    parameter int DB_CYCLES = 1_000_000,
    parameter int LP_CYCLES = 50_000_000
) (
    input  logic          sys_clk,
    input  logic          rst,
    key_debounce_if.slave bus
);
    localparam int DB_W = $clog2(DB_CYCLES);
    localparam int LP_W = $clog2(LP_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
    localparam logic [LP_W-1:0] LP_LAST = LP_W'(LP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_LONG     = 2'd2
    } state_t;

    logic [N_KEYS-1:0] sync_q1;
    logic [N_KEYS-1:0] sync_q2;
    logic [N_KEYS-1:0] sync;
    logic [N_KEYS-1:0] level;
    logic [N_KEYS-1:0] accept;
    logic [DB_W-1:0]   db_cnt [N_KEYS];

    state_t            state      [N_KEYS];
    state_t            state_next [N_KEYS];
    logic [LP_W-1:0]   hold       [N_KEYS];
    logic [LP_W-1:0]   hold_next  [N_KEYS];
    logic [N_KEYS-1:0] press_d, release_d, long_d;
    logic [N_KEYS-1:0] press_q, release_q, long_q;
    logic [2*N_KEYS-1:0] state_dbg;

    // Synchroniser flops reset to the released (high) level so no phantom press.
    assign sync = ~sync_q2;

    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            accept[i] = (sync[i] != level[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
            level   <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_q1 <= bus.key_n;
            sync_q2 <= sync_q1;
            for (int i = 0; i < N_KEYS; i++) begin
                if ((sync[i] == level[i]) || accept[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
                if (accept[i]) begin
                    level[i] <= sync[i];
                end
            end
        end
    end

    // Acceptance is decoded from the counter so the pulse lands on the same edge
    // as the level change; a release on the long-press edge takes priority.
    always_comb begin
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_next[i] = state[i];
            hold_next[i]  = hold[i];
            case (state[i])
                ST_RELEASED: begin
                    if (accept[i] && sync[i]) begin
                        state_next[i] = ST_PRESSED;
                        hold_next[i]  = '0;
                        press_d[i]    = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (accept[i] && !sync[i]) begin
                        state_next[i] = ST_RELEASED;
                        release_d[i]  = 1'b1;
                    end else if (hold[i] == LP_LAST) begin
                        state_next[i] = ST_LONG;
                        long_d[i]     = 1'b1;
                    end else begin
                        hold_next[i]  = hold[i] + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (accept[i] && !sync[i]) begin
                        state_next[i] = ST_RELEASED;
                        release_d[i]  = 1'b1;
                    end
                end
                default: begin
                    state_next[i] = ST_RELEASED;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= ST_RELEASED;
                hold[i]  <= '0;
            end
        end else begin
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int i = 0; i < N_KEYS; i++) begin
                state[i] <= state_next[i];
                hold[i]  <= hold_next[i];
            end
        end
    end

    always_comb begin
        state_dbg = '0;
        for (int i = 0; i < N_KEYS; i++) begin
            state_dbg[2*i +: 2] = state[i];
        end
    end

    assign bus.key_level   = level;
    assign bus.key_press   = press_q;
    assign bus.key_release = release_q;
    assign bus.key_long    = long_q;
    assign bus.key_state   = state_dbg;
endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=8 and LP_CYCLES=32.
// Sample index n means "just after the n-th rising edge following the stimulus".
module tb_key_debounce;
    localparam int N = 4;

    logic sys_clk = 1'b0;
    logic rst     = 1'b1;
    int   checks  = 0;
    int   errors  = 0;

    key_debounce_if #(.N_KEYS(N)) bus ();

    key_debounce #(
        .N_KEYS   (N),
        .DB_CYCLES(8),
        .LP_CYCLES(32)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 sys_clk = ~sys_clk;

    typedef struct {
        int key;
        int low_len;
        int exp_press_at;
        int exp_rel_at;
        int exp_long_at;
        int exp_long_cnt;
        int exp_level_cyc;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int outs_or();
        return int'(|{bus.key_level, bus.key_press, bus.key_release, bus.key_long});
    endfunction

    // Press key k for low_len edges, observe a window and summarise what key k did.
    task automatic run_press(input int k, input int low_len, input int win,
                             output int press_at, output int press_cnt,
                             output int rel_at, output int rel_cnt,
                             output int long_at, output int long_cnt,
                             output int level_cyc, output int others);
        logic [N-1:0] mask;
        mask = '0;
        mask[k] = 1'b1;
        press_at = -1; press_cnt = 0; rel_at = -1; rel_cnt = 0;
        long_at = -1; long_cnt = 0; level_cyc = 0; others = 0;
        @(negedge sys_clk);
        bus.key_n[k] = 1'b0;
        for (int n = 0; n < win; n++) begin
            tick();
            if (bus.key_press[k]) begin
                if (press_at < 0) press_at = n;
                press_cnt++;
            end
            if (bus.key_release[k]) begin
                if (rel_at < 0) rel_at = n;
                rel_cnt++;
            end
            if (bus.key_long[k]) begin
                if (long_at < 0) long_at = n;
                long_cnt++;
            end
            if (bus.key_level[k]) level_cyc++;
            if (|((bus.key_press | bus.key_release | bus.key_long | bus.key_level) & ~mask))
                others++;
            if (n == low_len - 1) bus.key_n[k] = 1'b1;
        end
    endtask

    initial begin
        int pa, pc, ra, rc, la, lc, lv, ot, busy;
        string tag;

        vecs[0] = '{0, 10, 9, 19, -1, 0, 10};
        vecs[1] = '{3, 20, 9, 29, -1, 0, 20};
        vecs[2] = '{2, 60, 9, 69, 41, 1, 60};
        vecs[3] = '{1, 32, 9, 41, -1, 0, 32};
        vecs[4] = '{1, 33, 9, 42, 41, 1, 33};
        vecs[5] = '{0,  7, -1, -1, -1, 0, 0};
        vecs[6] = '{0,  8, 9, 17, -1, 0, 8};

        // Reset with every key held down; outputs must stay quiet throughout.
        bus.key_n = 4'b0000;
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("reset_quiet_c%0d", c), outs_or(), 0);
        end
        rst = 1'b0;

        // All four keys were held through reset: coincident presses at index 9.
        for (int n = 0; n < 11; n++) begin
            tick();
            if (n == 8) begin
                check("all_level_before", int'(bus.key_level), 0);
                check("all_press_before", int'(bus.key_press), 0);
            end
            if (n == 9) begin
                check("all_level_at9", int'(bus.key_level), 15);
                check("all_press_at9", int'(bus.key_press), 15);
            end
            if (n == 10) check("all_press_gone", int'(bus.key_press), 0);
        end
        bus.key_n = 4'b1111;
        busy = 0;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (n == 9) check("all_release_at9", int'(bus.key_release), 15);
            if (n == 9) check("all_level_low9", int'(bus.key_level), 0);
            if (bus.key_long != 0) busy++;
        end
        check("all_no_long", busy, 0);

        for (int v = 0; v < 7; v++) begin
            run_press(vecs[v].key, vecs[v].low_len, vecs[v].low_len + 15,
                      pa, pc, ra, rc, la, lc, lv, ot);
            tag = $sformatf("k%0d_L%0d", vecs[v].key, vecs[v].low_len);
            check({tag, "_press_at"},   pa, vecs[v].exp_press_at);
            check({tag, "_press_cnt"},  pc, (vecs[v].exp_press_at >= 0) ? 1 : 0);
            check({tag, "_rel_at"},     ra, vecs[v].exp_rel_at);
            check({tag, "_rel_cnt"},    rc, (vecs[v].exp_rel_at >= 0) ? 1 : 0);
            check({tag, "_long_at"},    la, vecs[v].exp_long_at);
            check({tag, "_long_cnt"},   lc, vecs[v].exp_long_cnt);
            check({tag, "_level_cyc"},  lv, vecs[v].exp_level_cyc);
            check({tag, "_others"},     ot, 0);
            for (int g = 0; g < 3; g++) tick();
        end

        // Bounce on key1: low 5, high 2, low 7, then high; nothing may be accepted.
        busy = 0;
        @(negedge sys_clk);
        bus.key_n[1] = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            busy += outs_or();
            if (n == 4)  bus.key_n[1] = 1'b1;
            if (n == 6)  bus.key_n[1] = 1'b0;
            if (n == 13) bus.key_n[1] = 1'b1;
        end
        check("bounce_activity", busy, 0);

        // Reset while key0 is in LONG, keep holding, expect a fresh press.
        la = -1;
        @(negedge sys_clk);
        bus.key_n[0] = 1'b0;
        for (int n = 0; n < 45; n++) begin
            tick();
            if (bus.key_long[0] && la < 0) la = n;
        end
        check("midrst_long_at", la, 41);
        check("midrst_state_long", int'(bus.key_state[1:0]), 2);
        rst = 1'b1;
        busy = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            busy += outs_or();
        end
        check("midrst_quiet", busy, 0);
        check("midrst_state_rel", int'(bus.key_state[1:0]), 0);
        rst = 1'b0;
        pa = -1; rc = 0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (bus.key_press[0] && pa < 0) pa = n;
            if (bus.key_release != 0) rc++;
        end
        check("midrst_repress_at", pa, 9);
        check("midrst_no_release", rc, 0);
        bus.key_n[0] = 1'b1;
        ra = -1;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (bus.key_release[0] && ra < 0) ra = n;
        end
        check("midrst_release_at", ra, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
